instruction_fetch_stage: RTL and testbench
==========================================

// Module: instruction_fetch_stage
// PURPOSE
//  IF stage: owns the PC and fetches one instruction per request from a handshaked instruction memory.
//  Registered outputs feed the IF/ID pipeline register (instruction, PC+4, valid).
//  Supports downstream stall, branch/jump redirect with in-flight kill, and a 1-entry skid buffer.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  PC_STEP   4              sequential PC increment in bytes
// PORTS
//  clock           in   1   one clock; all state on posedge
//  reset           in   1   reset is asynchronous and active-low (asserted at 0)
//  stall           in   1   1 = hold IF outputs, do not consume fetched data
//  redirect        in   1   1 = flush and restart fetch at redirect_pc
//  redirect_pc     in   32  redirect target; bits[1:0] forced to 0
//  imem_req        out  1   fetch request valid
//  imem_addr       out  32  fetch address; stable while imem_req && !imem_ready
//  imem_ready      in   1   memory accepts request this cycle
//  imem_rvalid     in   1   read data valid (one pulse per accepted request)
//  imem_rdata      in   32  read data
//  IF_instruction  out  32  fetched instruction (0 = NOP bubble)
//  IF_pc_register  out  32  fetch address + PC_STEP
//  IF_valid        out  1   IF_instruction is a real instruction
// BEHAVIOUR
//  Reset (async, reset==0): pc=RESET_PC, state=REQ, kill=0, skid empty, IF_instruction=0,
//   IF_pc_register=0, IF_valid=0; imem_req=0 while reset is asserted.
//  Single outstanding request. imem_req = (state==REQ) && reset; imem_addr = pc.
//  FSM:
//   REQ : imem_ready -> latch req_addr=pc, go WAIT.
//   WAIT: imem_rvalid && kill -> drop data, kill=0, go REQ.
//         imem_rvalid && !kill && !stall -> load outputs, pc=req_addr+PC_STEP, go REQ.
//         imem_rvalid && !kill && stall -> store in skid, pc=req_addr+PC_STEP, go HOLD.
//   HOLD: !stall -> load outputs from skid, go REQ.
//  Output regs: stall==1 -> hold; stall==0 -> load the available instruction, else load a
//   bubble (IF_valid=0, IF_instruction=0, IF_pc_register=0).
//  Load = IF_instruction<=data, IF_pc_register<=req_addr+PC_STEP, IF_valid<=1.
//  Latency: accept at N, rvalid at N+1 -> IF_valid=1 at N+2; max 1 instr per 2 cycles.
//  Redirect (priority over stall and all FSM rules):
//   pc<={redirect_pc[31:2],2'b00}; output regs <= bubble even if stall=1.
//   REQ with imem_ready same cycle -> WAIT, kill=1.
//   REQ without imem_ready -> stay REQ.
//   WAIT without rvalid -> kill=1, stay WAIT.
//   WAIT with rvalid same cycle -> drop data, go REQ.
//   HOLD -> discard skid, go REQ.
//  imem_rvalid outside WAIT: ignored.
//  PC arithmetic is 32-bit modulo: 0xFFFF_FFFC + 4 = 0x0000_0000.
//  Reset mid-operation: immediate return to reset values; the memory shares the same reset,
//   so no stale response arrives after release.
// TESTING
//  1 Release reset; ready=1, rvalid at +1 with 0x2008_0005 -> IF_valid=1, IF_instruction=0x2008_0005,
//    IF_pc_register=0x4; next imem_addr=0x4.
//  2 Stall=1 for 3 cycles while rvalid arrives -> outputs hold prior values.
//    On stall=0, skid instr appears once; no loss, no duplicate.
//  3 Redirect to 0x103 in WAIT; rvalid 2 cycles later -> data dropped; imem_addr=0x100;
//    then IF_pc_register=0x104.
//  4 Redirect + rvalid + stall in the same cycle -> IF_valid=0, data dropped, next imem_addr=redirect.
//  5 imem_ready=0 for 5 cycles -> imem_req=1, imem_addr stable, IF_valid=0 each cycle.
//  6 Assert reset mid-WAIT; pc starts at 0xFFFF_FFFC -> outputs 0 asynchronously, pc=RESET_PC.
//    Separately, a fetch at 0xFFFF_FFFC yields IF_pc_register=0 and next imem_addr=0.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage
//   IF stage. Owns the PC and fetches one instruction at a time from a
//   handshaked instruction memory, with a single request outstanding.
//   The outputs are registered and feed the IF/ID pipeline register.
//   Supports a downstream stall, a branch/jump redirect that kills any
//   in-flight fetch, and a 1-entry skid buffer. The skid buffer catches a
//   response that arrives while the stage is stalled.
//
// Ports
//   clock          : clock, all state on posedge
//   reset          : asynchronous reset, active low
//   stall          : hold IF outputs, do not consume fetched data
//   redirect       : flush and restart fetch at redirect_pc (beats stall)
//   redirect_pc    : redirect target, bits [1:0] are ignored
//   imem_req       : fetch request valid
//   imem_addr      : fetch address (current pc)
//   imem_ready     : memory accepts the request this cycle
//   imem_rvalid    : read data valid, one pulse per accepted request
//   imem_rdata     : read data
//   IF_instruction : fetched instruction, 0 for a bubble
//   IF_pc_register : fetch address + PC_STEP, 0 for a bubble
//   IF_valid       : IF_instruction holds a real instruction
module instruction_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] IF_instruction,
   output logic [31:0] IF_pc_register,
   output logic        IF_valid
);

   localparam logic [31:0] STEP = 32'(PC_STEP);

   typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_HOLD} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] req_addr;   // address of the request in flight or in skid
   logic [31:0] skid_data;
   logic        kill;       // in-flight response must be dropped
   logic [31:0] seq_pc;     // wraps modulo 2^32

   assign seq_pc    = req_addr + STEP;
   // Gating with reset keeps the request low while reset is asserted.
   assign imem_req  = (state == ST_REQ) && reset;
   assign imem_addr = pc;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= ST_REQ;
         pc             <= RESET_PC;
         req_addr       <= RESET_PC;
         skid_data      <= '0;
         kill           <= 1'b0;
         IF_instruction <= '0;
         IF_pc_register <= '0;
         IF_valid       <= 1'b0;
      end else if (redirect) begin
         // A redirect always bubbles the outputs, even under stall.
         pc             <= {redirect_pc[31:2], 2'b00};
         IF_instruction <= '0;
         IF_pc_register <= '0;
         IF_valid       <= 1'b0;
         case (state)
            ST_REQ: if (imem_ready) begin
               // The old-path request is still accepted, so its response must be killed.
               req_addr <= pc;
               kill     <= 1'b1;
               state    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (imem_rvalid) begin
                  kill  <= 1'b0;
                  state <= ST_REQ;
               end else begin
                  kill  <= 1'b1;
               end
            end
            default: state <= ST_REQ;   // ST_HOLD: skid contents discarded
         endcase
      end else begin
         // Without a stall, default to a bubble; a ready instruction below overrides it.
         if (!stall) begin
            IF_instruction <= '0;
            IF_pc_register <= '0;
            IF_valid       <= 1'b0;
         end
         case (state)
            ST_REQ: if (imem_ready) begin
               req_addr <= pc;
               state    <= ST_WAIT;
            end
            ST_WAIT: if (imem_rvalid) begin
               if (kill) begin
                  kill  <= 1'b0;
                  state <= ST_REQ;
               end else begin
                  pc <= seq_pc;
                  if (stall) begin
                     skid_data <= imem_rdata;
                     state     <= ST_HOLD;
                  end else begin
                     IF_instruction <= imem_rdata;
                     IF_pc_register <= seq_pc;
                     IF_valid       <= 1'b1;
                     state          <= ST_REQ;
                  end
               end
            end
            ST_HOLD: if (!stall) begin
               IF_instruction <= skid_data;
               IF_pc_register <= seq_pc;
               IF_valid       <= 1'b1;
               state          <= ST_REQ;
            end
            default: state <= ST_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int unsigned PC_STEP  = 4;

   logic        clock, reset, stall, redirect, imem_ready, imem_rvalid;
   logic        imem_req, IF_valid;
   logic [31:0] redirect_pc, imem_addr, imem_rdata, IF_instruction, IF_pc_register;

   int vectors     = 0;
   int miscompares = 0;

   instruction_fetch_stage #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
      .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .IF_instruction(IF_instruction), .IF_pc_register(IF_pc_register),
      .IF_valid(IF_valid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: requests in flight form a queue, each tagged killed or
   // live. A held response sits in the skid slot. The stage requests only when
   // both are empty.
   typedef struct {
      logic [31:0] addr;
      bit          killed;
   } pend_t;

   pend_t       pend_q[$];
   logic [31:0] m_pc, m_skid_data, m_skid_addr, e_instr, e_pcreg;
   bit          m_skid_full, e_valid;

   task automatic model_reset();
      pend_q.delete();
      m_pc        = RESET_PC;
      m_skid_full = 0;
      m_skid_data = '0;
      m_skid_addr = '0;
      e_valid     = 0;
      e_instr     = '0;
      e_pcreg     = '0;
   endtask

   // Applies one clock edge's worth of the rules to the current inputs.
   task automatic model_step();
      bit          asking, have, from_mem;
      logic [31:0] d, a;
      pend_t       f;
      asking   = (pend_q.size() == 0) && !m_skid_full;
      have     = 0;
      from_mem = 0;
      d        = '0;
      a        = '0;
      if (m_skid_full) begin
         have = 1; d = m_skid_data; a = m_skid_addr;
      end else if (pend_q.size() > 0 && imem_rvalid) begin
         f = pend_q.pop_front();
         if (!f.killed && !redirect) begin
            have = 1; from_mem = 1; d = imem_rdata; a = f.addr + PC_STEP;
            m_pc = a;
         end
      end
      if (asking && imem_ready) pend_q.push_back('{addr: m_pc, killed: redirect});
      if (redirect) begin
         m_pc = {redirect_pc[31:2], 2'b00};
         foreach (pend_q[i]) pend_q[i].killed = 1;
         m_skid_full = 0;
         e_valid = 0; e_instr = '0; e_pcreg = '0;
      end else if (!stall) begin
         m_skid_full = 0;
         if (have) begin
            e_valid = 1; e_instr = d; e_pcreg = a;
         end else begin
            e_valid = 0; e_instr = '0; e_pcreg = '0;
         end
      end else if (from_mem) begin
         m_skid_full = 1; m_skid_data = d; m_skid_addr = a;
      end
   endtask

   function automatic logic [97:0] observed();
      return {imem_req, imem_addr, IF_valid, IF_instruction, IF_pc_register};
   endfunction

   function automatic logic [97:0] predicted();
      logic r;
      r = (reset === 1'b1) && (pend_q.size() == 0) && !m_skid_full;
      return {r, m_pc, e_valid, e_instr, e_pcreg};
   endfunction

   task automatic tick();
      model_step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      logic [97:0] got;
      @(posedge clock); #1;
      got = observed();
      vectors++;
      if (got !== {1'b0, RESET_PC, 1'b0, 32'h0, 32'h0}) begin
         miscompares++; $display("FAIL reset_hold got=%h want=%h", got, {1'b0, RESET_PC, 65'h0});
      end
      reset = 1'b1; model_reset(); #1;
      got = observed();
      vectors++;
      if (got !== {1'b1, RESET_PC, 65'h0}) begin
         miscompares++; $display("FAIL reset_release got=%h want=%h", got, {1'b1, RESET_PC, 65'h0});
      end
   endtask

   task automatic test_basic_fetch();
      logic [97:0] got;
      imem_ready = 1; tick(); imem_ready = 0;
      got = observed(); vectors++;
      if (got !== {1'b0, 32'h0, 65'h0}) begin
         miscompares++; $display("FAIL t1_wait got=%h want=%h", got, {1'b0, 32'h0, 65'h0});
      end
      imem_rvalid = 1; imem_rdata = 32'h2008_0005; tick(); imem_rvalid = 0;
      got = observed(); vectors++;
      if (got !== {1'b1, 32'h4, 1'b1, 32'h2008_0005, 32'h4}) begin
         miscompares++; $display("FAIL t1_fetch got=%h want=%h", got, {1'b1, 32'h4, 1'b1, 32'h2008_0005, 32'h4});
      end
   endtask

   task automatic test_stall_skid();
      logic [97:0] got;
      stall = 1; imem_ready = 1; tick(); imem_ready = 0;
      got = observed(); vectors++;
      if (got !== {1'b0, 32'h4, 1'b1, 32'h2008_0005, 32'h4}) begin
         miscompares++; $display("FAIL t2_stall1 got=%h want=%h", got, {1'b0, 32'h4, 1'b1, 32'h2008_0005, 32'h4});
      end
      imem_rvalid = 1; imem_rdata = 32'h1111_1111; tick(); imem_rvalid = 0;
      for (int i = 0; i < 2; i++) begin
         got = observed(); vectors++;
         if (got !== {1'b0, 32'h8, 1'b1, 32'h2008_0005, 32'h4}) begin
            miscompares++; $display("FAIL t2_hold%0d got=%h want=%h", i, got, {1'b0, 32'h8, 1'b1, 32'h2008_0005, 32'h4});
         end
         if (i == 0) tick();
      end
      stall = 0; tick();
      got = observed(); vectors++;
      if (got !== {1'b1, 32'h8, 1'b1, 32'h1111_1111, 32'h8}) begin
         miscompares++; $display("FAIL t2_skid_out got=%h want=%h", got, {1'b1, 32'h8, 1'b1, 32'h1111_1111, 32'h8});
      end
      tick();
      got = observed(); vectors++;
      if (got !== {1'b1, 32'h8, 65'h0}) begin
         miscompares++; $display("FAIL t2_no_dup got=%h want=%h", got, {1'b1, 32'h8, 65'h0});
      end
   endtask

   task automatic test_redirect_wait();
      logic [97:0] got;
      imem_ready = 1; tick(); imem_ready = 0;
      redirect = 1; redirect_pc = 32'h103; tick(); redirect = 0;
      got = observed(); vectors++;
      if (got !== {1'b0, 32'h100, 65'h0}) begin
         miscompares++; $display("FAIL t3_killwait got=%h want=%h", got, {1'b0, 32'h100, 65'h0});
      end
      tick();
      imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; tick(); imem_rvalid = 0;
      got = observed(); vectors++;
      if (got !== {1'b1, 32'h100, 65'h0}) begin
         miscompares++; $display("FAIL t3_dropped got=%h want=%h", got, {1'b1, 32'h100, 65'h0});
      end
      imem_ready = 1; tick(); imem_ready = 0;
      imem_rvalid = 1; imem_rdata = 32'h3333_3333; tick(); imem_rvalid = 0;
      got = observed(); vectors++;
      if (got !== {1'b1, 32'h104, 1'b1, 32'h3333_3333, 32'h104}) begin
         miscompares++; $display("FAIL t3_target got=%h want=%h", got, {1'b1, 32'h104, 1'b1, 32'h3333_3333, 32'h104});
      end
   endtask

   task automatic test_redirect_rvalid_stall();
      logic [97:0] got;
      imem_ready = 1; tick(); imem_ready = 0;
      redirect = 1; imem_rvalid = 1; stall = 1; redirect_pc = 32'h200; imem_rdata = 32'h4444_4444;
      tick();
      redirect = 0; imem_rvalid = 0; stall = 0;
      got = observed(); vectors++;
      if (got !== {1'b1, 32'h200, 65'h0}) begin
         miscompares++; $display("FAIL t4_combo got=%h want=%h", got, {1'b1, 32'h200, 65'h0});
      end
   endtask

   task automatic test_ready_low();
      logic [97:0] got;
      for (int i = 0; i < 5; i++) begin
         tick();
         got = observed(); vectors++;
         if (got !== {1'b1, 32'h200, 65'h0}) begin
            miscompares++; $display("FAIL t5_noready%0d got=%h want=%h", i, got, {1'b1, 32'h200, 65'h0});
         end
      end
   endtask

   task automatic test_reset_wrap();
      logic [97:0] got;
      redirect = 1; redirect_pc = 32'hFFFF_FFFC; tick(); redirect = 0;
      imem_ready = 1; tick(); imem_ready = 0;
      got = observed(); vectors++;
      if (got !== {1'b0, 32'hFFFF_FFFC, 65'h0}) begin
         miscompares++; $display("FAIL t6_wait_top got=%h want=%h", got, {1'b0, 32'hFFFF_FFFC, 65'h0});
      end
      #2 reset = 0; #1;
      got = observed(); vectors++;
      if (got !== {1'b0, RESET_PC, 65'h0}) begin
         miscompares++; $display("FAIL t6_async_pc got=%h want=%h", got, {1'b0, RESET_PC, 65'h0});
      end
      @(posedge clock); #1 reset = 1; model_reset(); #1;
      got = observed(); vectors++;
      if (got !== {1'b1, RESET_PC, 65'h0}) begin
         miscompares++; $display("FAIL t6_restart got=%h want=%h", got, {1'b1, RESET_PC, 65'h0});
      end
      // Fetch at the top of the address space wraps to zero.
      redirect = 1; redirect_pc = 32'hFFFF_FFFC; tick(); redirect = 0;
      imem_ready = 1; tick(); imem_ready = 0;
      imem_rvalid = 1; imem_rdata = 32'h5555_5555; tick(); imem_rvalid = 0;
      got = observed(); vectors++;
      if (got !== {1'b1, 32'h0, 1'b1, 32'h5555_5555, 32'h0}) begin
         miscompares++; $display("FAIL t6_wrap got=%h want=%h", got, {1'b1, 32'h0, 1'b1, 32'h5555_5555, 32'h0});
      end
      stall = 1; imem_ready = 1; tick(); imem_ready = 0;
      #2 reset = 0; #1;
      got = observed(); vectors++;
      if (got !== {1'b0, RESET_PC, 65'h0}) begin
         miscompares++; $display("FAIL t6_async_out got=%h want=%h", got, {1'b0, RESET_PC, 65'h0});
      end
      stall = 0;
      @(posedge clock); #1 reset = 1; model_reset(); #1;
   endtask

   task automatic test_random();
      logic [97:0] got, exp;
      for (int i = 0; i < 3000; i++) begin
         stall       = ($urandom_range(0, 3) == 0);
         redirect    = ($urandom_range(0, 11) == 0);
         redirect_pc = $urandom;
         imem_ready  = $urandom_range(0, 1);
         imem_rvalid = (pend_q.size() > 0) ? ($urandom_range(0, 2) != 0)
                                           : ($urandom_range(0, 15) == 0);
         imem_rdata  = $urandom;
         tick();
         got = observed();
         exp = predicted();
         vectors++;
         if (got !== exp) begin
            miscompares++; $display("FAIL rand_cycle%0d got=%h want=%h", i, got, exp);
         end
      end
      stall = 0; redirect = 0; imem_ready = 0; imem_rvalid = 0;
   endtask

   initial begin
      reset = 0; stall = 0; redirect = 0; redirect_pc = '0;
      imem_ready = 0; imem_rvalid = 0; imem_rdata = '0;
      model_reset();
      test_reset();
      test_basic_fetch();
      test_stall_skid();
      test_redirect_wait();
      test_redirect_rvalid_stall();
      test_ready_low();
      test_reset_wrap();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
